// File: rtl/bft_pkt_pkg.sv
// Shared BFT leaf packet definitions: field positions, packet type codes
// and the sender FSM state encoding.
package bft_pkt_pkg;

  localparam int VLD_BIT  = 48;
  localparam int LEAF_MSB = 47;
  localparam int LEAF_LSB = 44;
  localparam int PORT_MSB = 43;
  localparam int PORT_LSB = 40;
  localparam int ADDR_MSB = 39;
  localparam int ADDR_LSB = 33;
  localparam int TYPE_BIT = 32;

  localparam logic TYPE_DATA      = 1'b0;
  localparam logic TYPE_FREESPACE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESEND = 2'd2
  } sender_state_e;

endpackage

// File: rtl/bft_stream_sender_if.sv
// Stream-side and network-side buses of the BFT stream sender.
// master = kernel/network side driving the sender, slave = the sender.
interface bft_stream_sender_if #(
  parameter int PAYLOAD_BITS = 32,
  parameter int PACKET_BITS  = 49
);
  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic                    vld_user2interface;
  logic                    ack_interface2user;
  logic [PACKET_BITS-1:0]  din_leaf_bft2interface;
  logic [PACKET_BITS-1:0]  dout_leaf_interface2bft;

  modport master (
    output din_leaf_user2interface,
    output vld_user2interface,
    input  ack_interface2user,
    output din_leaf_bft2interface,
    input  dout_leaf_interface2bft
  );

  modport slave (
    input  din_leaf_user2interface,
    input  vld_user2interface,
    output ack_interface2user,
    input  din_leaf_bft2interface,
    output dout_leaf_interface2bft
  );
endinterface

// File: rtl/bft_credit_counter.sv
// Destination credit counter: starts full, drops by one per sent packet,
// rises by a fixed bulk amount per freespace return, saturates at the
// initial value and raises a sticky overflow flag when it would exceed it.
module bft_credit_counter #(
  parameter int CREDIT_BITS = 8,
  parameter int INIT_CREDIT = 128,
  parameter int INC_SIZE    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec,
  input  logic                   inc,
  output logic [CREDIT_BITS-1:0] credit,
  output logic                   overflow
);
  localparam int SUM_W = CREDIT_BITS + 1;
  localparam logic [SUM_W-1:0] MAX_W = SUM_W'(INIT_CREDIT);
  localparam logic [SUM_W-1:0] INC_W = SUM_W'(INC_SIZE);

  logic [SUM_W-1:0] sum;

  function automatic logic is_over(input logic [SUM_W-1:0] s);
    return (s > MAX_W);
  endfunction

  function automatic logic [CREDIT_BITS-1:0] sat_credit(input logic [SUM_W-1:0] s);
    return is_over(s) ? MAX_W[CREDIT_BITS-1:0] : s[CREDIT_BITS-1:0];
  endfunction

  // Unsaturated next credit; one extra bit holds results up to MAX + INC.
  always_comb begin
    sum = {1'b0, credit} - {{CREDIT_BITS{1'b0}}, dec} + (inc ? INC_W : '0);
  end

  // Credit register and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit   <= MAX_W[CREDIT_BITS-1:0];
      overflow <= 1'b0;
    end else begin
      credit <= sat_credit(sum);
      if (is_over(sum)) overflow <= 1'b1;
    end
  end
endmodule

// File: rtl/bft_stream_sender.sv
// Single-port BFT transmit interface: turns accepted 32-bit stream words
// into data packets for one destination leaf/port under credit control.
// Optional feature macro: SENDER_RESEND_EN (last-packet re-emission on
// the resend pulse; without it resend is ignored and the FSM is IDLE/RUN).
module bft_stream_sender
  import bft_pkt_pkg::*;
#(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 4,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int DST_LEAF              = 0,
  parameter int DST_PORT              = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ap_start,
  input  logic               resend,
  output logic               credit_overflow,
  bft_stream_sender_if.slave bus
);
  localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
  localparam logic [NUM_LEAF_BITS-1:0] DST_LEAF_V = NUM_LEAF_BITS'(DST_LEAF);
  localparam logic [NUM_PORT_BITS-1:0] DST_PORT_V = NUM_PORT_BITS'(DST_PORT);

  sender_state_e            state_p0, state_nxt;
  logic [CREDIT_BITS-1:0]   credit;
  logic                     ack, xfer, credit_ret;
  logic [NUM_ADDR_BITS-1:0] seq_p0;
  logic [PACKET_BITS-1:0]   dout_p0, pkt_new, bft_in;
  logic                     unused_bft_bits;

  assign bft_in     = bus.din_leaf_bft2interface;
  assign credit_ret = bft_in[VLD_BIT] && (bft_in[TYPE_BIT] == TYPE_FREESPACE) &&
                      (bft_in[LEAF_MSB:LEAF_LSB] == DST_LEAF_V) &&
                      (bft_in[PORT_MSB:PORT_LSB] == DST_PORT_V);
  // Sequence address and payload of incoming packets carry no credit info.
  assign unused_bft_bits = ^{bft_in[ADDR_MSB:ADDR_LSB], bft_in[PAYLOAD_BITS-1:0]};

  assign pkt_new = {1'b1, DST_LEAF_V, DST_PORT_V, seq_p0, TYPE_DATA,
                    bus.din_leaf_user2interface};
  assign xfer    = ack && bus.vld_user2interface;

  assign bus.ack_interface2user      = ack;
  assign bus.dout_leaf_interface2bft = dout_p0;

`ifdef SENDER_RESEND_EN
  logic                   resend_go;
  logic                   have_last;
  logic [PACKET_BITS-1:0] last_pkt_p0;

  // Remember that a packet exists to resend; cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) have_last <= 1'b0;
    else if (xfer) have_last <= 1'b1;
  end

  // Copy of the most recent data packet for re-emission.
  always_ff @(posedge clk) begin
    if (xfer) last_pkt_p0 <= pkt_new;
  end
`else
  logic unused_resend;
  assign unused_resend = resend;
`endif

  bft_credit_counter #(
    .CREDIT_BITS (CREDIT_BITS),
    .INIT_CREDIT (1 << NUM_BRAM_ADDR_BITS),
    .INC_SIZE    (FREESPACE_UPDATE_SIZE)
  ) u_credit (
    .clk      (clk),
    .rst      (reset),
    .dec      (xfer),
    .inc      (credit_ret),
    .credit   (credit),
    .overflow (credit_overflow)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_p0 <= ST_IDLE;
    else       state_p0 <= state_nxt;
  end

  // Next state and stream ready; ack depends only on state, credit, resend.
  always_comb begin
    state_nxt = state_p0;
    ack       = 1'b0;
`ifdef SENDER_RESEND_EN
    resend_go = 1'b0;
`endif
    case (state_p0)
      ST_IDLE: if (ap_start) state_nxt = ST_RUN;
      ST_RUN: begin
`ifdef SENDER_RESEND_EN
        ack = (credit != '0) && !resend;
        if (resend && have_last) begin
          resend_go = 1'b1;
          state_nxt = ST_RESEND;
        end
`else
        ack = (credit != '0);
`endif
      end
`ifdef SENDER_RESEND_EN
      ST_RESEND: state_nxt = ST_RUN;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- stage p0: registered output packet and sequence counter ----
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_p0 <= '0;
      seq_p0  <= '0;
    end else if (xfer) begin
      dout_p0 <= pkt_new;
      seq_p0  <= seq_p0 + 1'b1;
`ifdef SENDER_RESEND_EN
    end else if (resend_go) begin
      dout_p0 <= last_pkt_p0;
`endif
    end else begin
      dout_p0[VLD_BIT] <= 1'b0;
    end
  end
endmodule
